// File: rtl/fft8_out_serializer.sv
// Ping-pong output buffer for the 8-point FFT: captures a parallel complex frame
// in one cycle and streams it out one sample per beat over valid/ready.
//
// bank state | meaning
// EMPTY      | bank may be written by the next accepted frame
// FULL       | bank holds a frame that is still draining (or waiting to drain)
module fft8_out_serializer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real0,
    input  logic [DATA_W-1:0] in_real1,
    input  logic [DATA_W-1:0] in_real2,
    input  logic [DATA_W-1:0] in_real3,
    input  logic [DATA_W-1:0] in_real4,
    input  logic [DATA_W-1:0] in_real5,
    input  logic [DATA_W-1:0] in_real6,
    input  logic [DATA_W-1:0] in_real7,
    input  logic [DATA_W-1:0] in_imag0,
    input  logic [DATA_W-1:0] in_imag1,
    input  logic [DATA_W-1:0] in_imag2,
    input  logic [DATA_W-1:0] in_imag3,
    input  logic [DATA_W-1:0] in_imag4,
    input  logic [DATA_W-1:0] in_imag5,
    input  logic [DATA_W-1:0] in_imag6,
    input  logic [DATA_W-1:0] in_imag7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_st_t;

    bank_st_t          st_q [2];
    bank_st_t          st_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [2:0]        rd_idx_q, rd_idx_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0] bank_re_q [2][8];
    logic [DATA_W-1:0] bank_im_q [2][8];
    logic [DATA_W-1:0] in_re [8];
    logic [DATA_W-1:0] in_im [8];

    logic capture;
    logic drop;
    logic beat;

    assign in_re[0] = in_real0;
    assign in_re[1] = in_real1;
    assign in_re[2] = in_real2;
    assign in_re[3] = in_real3;
    assign in_re[4] = in_real4;
    assign in_re[5] = in_real5;
    assign in_re[6] = in_real6;
    assign in_re[7] = in_real7;
    assign in_im[0] = in_imag0;
    assign in_im[1] = in_imag1;
    assign in_im[2] = in_imag2;
    assign in_im[3] = in_imag3;
    assign in_im[4] = in_imag4;
    assign in_im[5] = in_imag5;
    assign in_im[6] = in_imag6;
    assign in_im[7] = in_imag7;

    // Handshake flags come from registers only, so no comb path crosses the block.
    assign in_ready  = (st_q[wr_sel_q] == EMPTY);
    assign out_valid = (st_q[rd_sel_q] == FULL);
    assign capture   = in_valid && in_ready;
    assign drop      = in_valid && !in_ready;
    assign beat      = out_valid && out_ready;

    assign out_real = out_valid ? bank_re_q[rd_sel_q][rd_idx_q] : '0;
    assign out_imag = out_valid ? bank_im_q[rd_sel_q][rd_idx_q] : '0;
    assign out_idx  = out_valid ? rd_idx_q : 3'd0;
    assign out_last = out_valid && (rd_idx_q == 3'd7);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    // Capture needs wr_sel EMPTY and a last beat needs rd_sel FULL,
    // so both updates below always land on different banks.
    always_comb begin
        st_d[0]    = st_q[0];
        st_d[1]    = st_q[1];
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        rd_idx_d   = rd_idx_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (capture) begin
            st_d[wr_sel_q] = FULL;
            wr_sel_d       = ~wr_sel_q;
        end

        if (beat) begin
            rd_idx_d = rd_idx_q + 3'd1;
            if (rd_idx_q == 3'd7) begin
                st_d[rd_sel_q] = EMPTY;
                rd_sel_d       = ~rd_sel_q;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]    <= EMPTY;
            st_q[1]    <= EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_idx_q   <= 3'd0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            st_q[0]    <= st_d[0];
            st_q[1]    <= st_d[1];
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            rd_idx_q   <= rd_idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            for (int i = 0; i < 8; i++) begin
                bank_re_q[wr_sel_q][i] <= in_re[i];
                bank_im_q[wr_sel_q][i] <= in_im[i];
            end
        end
    end

endmodule
